// File: rtl/wb_port_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_port_scheduler_pkg                                     |
// | Purpose  : Write-back select codes, operand bundle type and helpers  |
// |            shared by the write-port scheduler slice.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package wb_port_scheduler_pkg;

  // Write-back source select codes (register-file write-back encoding)
  localparam logic [1:0] REG_WB_MEM_DAT = 2'b00;
  localparam logic [1:0] REG_WB_ALU_OUT = 2'b01;
  localparam logic [1:0] REG_WB_IMM_DAT = 2'b10;
  localparam logic [1:0] REG_WB_PC_NEXT = 2'b11;

  // Registered operand set presented to the write-back mux
  typedef struct packed {
    logic [31:0] mem;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] pcn;
  } wb_operands_t;

  // One-hot scoreboard bit for a register; x0 never gets a bit
  function automatic logic [31:0] rd_bit(input logic [4:0] rd);
    rd_bit = '0;
    if (rd != 5'd0) rd_bit[rd] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_port_scheduler_if                                      |
// | Purpose  : Execute, load-issue, load-done and register-file write    |
// |            signals of the write-port scheduler.                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface wb_port_scheduler_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_wb_sel;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu;
  logic [31:0] ex_imm;
  logic [31:0] ex_pcn;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic        ld_done_valid;
  logic [31:0] ld_done_data;
  logic [31:0] busy_mask;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        err_underflow;

  // Upstream side: execute/LSU stages and register-file observer
  modport master (
    output ex_valid, ex_wb_sel, ex_rd, ex_alu, ex_imm, ex_pcn,
    output ld_issue_valid, ld_issue_rd, ld_done_valid, ld_done_data,
    input  ex_ready, ld_issue_ready, busy_mask, rf_we, rf_rd, rf_wdata, err_underflow
  );

  // Scheduler side
  modport slave (
    input  ex_valid, ex_wb_sel, ex_rd, ex_alu, ex_imm, ex_pcn,
    input  ld_issue_valid, ld_issue_rd, ld_done_valid, ld_done_data,
    output ex_ready, ld_issue_ready, busy_mask, rf_we, rf_rd, rf_wdata, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_scheduler_write_back_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_port_scheduler_write_back_unit                         |
// | Purpose  : Write-back data mux selecting the register-file write     |
// |            data from the registered operand set.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module wb_port_scheduler_write_back_unit
  import wb_port_scheduler_pkg::*;
(
  input  logic [1:0]   wb_sel,
  input  wb_operands_t ops,
  output logic [31:0]  wdata
);

  // Select the write data according to the registered source code
  always_comb begin
    wdata = '0;
    case (wb_sel)
      REG_WB_MEM_DAT: wdata = ops.mem;
      REG_WB_ALU_OUT: wdata = ops.alu;
      REG_WB_IMM_DAT: wdata = ops.imm;
      REG_WB_PC_NEXT: wdata = ops.pcn;
      default:        wdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_port_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wb_port_scheduler                                         |
// | Purpose  : Arbitrates the single register-file write port between    |
// |            execute results and in-order load completions; tracks     |
// |            pending load destinations in a FIFO plus busy scoreboard. |
// | Config   : WB_WAW_STALL_EN - stall execute writes whose rd has a     |
// |            pending load (keeps program-order WAW).                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module wb_port_scheduler
  import wb_port_scheduler_pkg::*;
#(
  parameter int MAX_LOADS = 4
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_scheduler_if.slave bus
);

  localparam int c_PTR_W = $clog2(MAX_LOADS);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [4:0]         r_fifo [MAX_LOADS];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_busy;
  logic               r_err;

  logic               r_rf_we;
  logic [4:0]         r_rf_rd;
  logic [1:0]         r_wb_sel;
  wb_operands_t       r_ops;

  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_pop;
  logic               w_push;
  logic [4:0]         w_pop_rd;
  logic               w_ex_waw_block;
  logic               w_ex_fire;
  logic [31:0]        w_busy_next;
  logic [31:0]        w_rf_wdata;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == c_CNT_W'(MAX_LOADS));
  assign w_pop_rd     = r_fifo[r_rd_ptr];
  // A load completion with nothing outstanding is dropped, not popped
  assign w_pop        = bus.ld_done_valid & ~w_fifo_empty;

`ifdef WB_WAW_STALL_EN
  assign w_ex_waw_block = r_busy[bus.ex_rd] & (bus.ex_rd != 5'd0);
`else
  assign w_ex_waw_block = 1'b0;
`endif

  // Load returns cannot be back-pressured, so they always own the port
  assign bus.ex_ready       = ~bus.ld_done_valid & ~w_ex_waw_block;
  // Readiness uses the registered count: a full FIFO stays full even if popping
  assign bus.ld_issue_ready = ~w_fifo_full & ~r_busy[bus.ld_issue_rd];
  assign w_push             = bus.ld_issue_valid & bus.ld_issue_ready;
  assign w_ex_fire          = bus.ex_valid & bus.ex_ready;

  // Scoreboard update: clear the retiring load, then mark the new one
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop)  w_busy_next = w_busy_next & ~rd_bit(w_pop_rd);
    if (w_push) w_busy_next = w_busy_next | rd_bit(bus.ld_issue_rd);
  end

  // Load-destination storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.ld_issue_rd;
  end

  // FIFO pointers, occupancy, scoreboard and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
      r_busy <= w_busy_next;
      if (bus.ld_done_valid & w_fifo_empty) r_err <= 1'b1;
    end
  end

  // Write-back stage register: one cycle from accept/pop to rf write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we  <= 1'b0;
      r_rf_rd  <= '0;
      r_wb_sel <= REG_WB_PC_NEXT;
      r_ops    <= '0;
    end else if (w_pop) begin
      r_rf_we  <= (w_pop_rd != 5'd0);
      r_rf_rd  <= w_pop_rd;
      r_wb_sel <= REG_WB_MEM_DAT;
      r_ops.mem <= bus.ld_done_data;
    end else if (w_ex_fire) begin
      r_rf_we  <= (bus.ex_rd != 5'd0);
      r_rf_rd  <= bus.ex_rd;
      r_wb_sel <= bus.ex_wb_sel;
      r_ops.alu <= bus.ex_alu;
      r_ops.imm <= bus.ex_imm;
      r_ops.pcn <= bus.ex_pcn;
    end else begin
      r_rf_we  <= 1'b0;
    end
  end

  wb_port_scheduler_write_back_unit u_write_back_unit (
    .wb_sel (r_wb_sel),
    .ops    (r_ops),
    .wdata  (w_rf_wdata)
  );

  assign bus.rf_we         = r_rf_we;
  assign bus.rf_rd         = r_rf_rd;
  assign bus.rf_wdata      = w_rf_wdata;
  assign bus.busy_mask     = r_busy;
  assign bus.err_underflow = r_err;

endmodule
`default_nettype wire
